// File: rtl/id_ex_stage_pkg.sv
// Shared widths, the EX pipeline register layout and the forwarding-match helper
// for the ID/EX stage.
package pipe_pkg;
  localparam int DW     = 32;
  localparam int RW     = 5;
  localparam int CTRL_W = 12;
  localparam logic [RW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic              valid;
    logic [RW-1:0]     ra;
    logic [RW-1:0]     rb;
    logic [RW-1:0]     rw;
    logic              regwr;
    logic              memtoreg;
    logic [DW-1:0]     a;
    logic [DW-1:0]     b;
    logic [DW-1:0]     imm;
    logic [CTRL_W-1:0] ctrl;
  } ex_reg_t;

  // r0 is hardwired, so a producer targeting it never feeds a consumer
  function automatic logic fwd_hit(logic wr, logic [RW-1:0] dst, logic [RW-1:0] src);
    return wr && (dst != REG_ZERO) && (dst == src);
  endfunction
endpackage

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: ID-side inputs, MEM/WB producer info, and the EX-side outputs.
interface id_ex_if;
  import pipe_pkg::*;

  logic              id_valid;
  logic [RW-1:0]     id_Ra, id_Rb, id_Rw;
  logic              id_RegWr, id_MemtoReg;
  logic [DW-1:0]     id_busA, id_busB, id_imm;
  logic [CTRL_W-1:0] id_ctrl;
  logic              flush;
  logic [RW-1:0]     mem_Rw, wb_Rw;
  logic              mem_RegWr, wb_RegWr;
  logic [DW-1:0]     mem_result, wb_busW;
  logic              stall;
  logic              ex_valid;
  logic [DW-1:0]     ex_A, ex_B, ex_imm;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [RW-1:0]     ex_Rw;
  logic              ex_RegWr, ex_MemtoReg;

  modport master (
    output id_valid, id_Ra, id_Rb, id_Rw, id_RegWr, id_MemtoReg,
           id_busA, id_busB, id_imm, id_ctrl, flush,
           mem_Rw, mem_RegWr, mem_result, wb_Rw, wb_RegWr, wb_busW,
    input  stall, ex_valid, ex_A, ex_B, ex_imm, ex_ctrl, ex_Rw, ex_RegWr, ex_MemtoReg
  );

  modport slave (
    input  id_valid, id_Ra, id_Rb, id_Rw, id_RegWr, id_MemtoReg,
           id_busA, id_busB, id_imm, id_ctrl, flush,
           mem_Rw, mem_RegWr, mem_result, wb_Rw, wb_RegWr, wb_busW,
    output stall, ex_valid, ex_A, ex_B, ex_imm, ex_ctrl, ex_Rw, ex_RegWr, ex_MemtoReg
  );
endinterface

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand select for one EX source: MEM result beats WB data beats the registered value.
module fwd_mux
  import pipe_pkg::*;
(
  input  logic [RW-1:0] src,
  input  logic [DW-1:0] reg_val,
  input  logic [RW-1:0] mem_rw,
  input  logic          mem_regwr,
  input  logic [DW-1:0] mem_result,
  input  logic [RW-1:0] wb_rw,
  input  logic          wb_regwr,
  input  logic [DW-1:0] wb_busw,
  output logic [DW-1:0] val
);
  always_comb begin
    val = reg_val;
    if (fwd_hit(mem_regwr, mem_rw, src))     val = mem_result;
    else if (fwd_hit(wb_regwr, wb_rw, src))  val = wb_busw;
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB bypass at capture, MEM/WB forwarding into EX,
// load-use stall/bubble and flush. HAZARD_STATS_EN adds stall/flush counters.
module id_ex_stage
  import pipe_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst_n,
  id_ex_if.slave      bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);
  ex_reg_t ex_q, ex_d;
  logic    hz;

  // Load in EX whose destination is read by ID: result not ready until MEM
  always_comb begin
    hz = bus.id_valid && ex_q.valid && ex_q.memtoreg && ex_q.regwr &&
         (ex_q.rw != REG_ZERO) && ((ex_q.rw == bus.id_Ra) || (ex_q.rw == bus.id_Rb));
  end

  assign bus.stall = hz && !bus.flush;

  always_comb begin
    ex_d = '0;
    if (!(bus.flush || hz)) begin
      ex_d.valid    = bus.id_valid;
      ex_d.ra       = bus.id_Ra;
      ex_d.rb       = bus.id_Rb;
      ex_d.rw       = bus.id_Rw;
      ex_d.regwr    = bus.id_RegWr;
      ex_d.memtoreg = bus.id_MemtoReg;
      ex_d.imm      = bus.id_imm;
      ex_d.ctrl     = bus.id_ctrl;
      // Regfile writes on this same edge, so its read data is stale on a WB match
      ex_d.a = fwd_hit(bus.wb_RegWr, bus.wb_Rw, bus.id_Ra) ? bus.wb_busW : bus.id_busA;
      ex_d.b = fwd_hit(bus.wb_RegWr, bus.wb_Rw, bus.id_Rb) ? bus.wb_busW : bus.id_busB;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  fwd_mux u_fwd_a (
    .src(ex_q.ra), .reg_val(ex_q.a),
    .mem_rw(bus.mem_Rw), .mem_regwr(bus.mem_RegWr), .mem_result(bus.mem_result),
    .wb_rw(bus.wb_Rw), .wb_regwr(bus.wb_RegWr), .wb_busw(bus.wb_busW),
    .val(bus.ex_A)
  );

  fwd_mux u_fwd_b (
    .src(ex_q.rb), .reg_val(ex_q.b),
    .mem_rw(bus.mem_Rw), .mem_regwr(bus.mem_RegWr), .mem_result(bus.mem_result),
    .wb_rw(bus.wb_Rw), .wb_regwr(bus.wb_RegWr), .wb_busw(bus.wb_busW),
    .val(bus.ex_B)
  );

  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_imm      = ex_q.imm;
  assign bus.ex_ctrl     = ex_q.ctrl;
  assign bus.ex_Rw       = ex_q.rw;
  assign bus.ex_RegWr    = ex_q.regwr;
  assign bus.ex_MemtoReg = ex_q.memtoreg;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, bus.stall};
    flush_cnt_d = flush_cnt_q + {31'd0, bus.flush};
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif
endmodule
